clint: RTL
==========

CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter: PRESCALE_DIV, default 16, mtime tick divisor (range 2..65535); used only when CLINT_PRESCALER_EN is defined.
REQ-002 clk  input  1  clock; reset resetn, asynchronous, active-low.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  bus request valid.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  16  byte offset; bits [1:0] ignored.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_wstrb  input  4  byte enables for writes.
REQ-010 resp_valid  output  1  response valid.
REQ-011 resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-012 resp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 resp_error  output  1  unmapped offset.
REQ-014 timer_interrupt  output  1  MTIP, feeds the CSR unit.
REQ-015 software_interrupt  output  1  MSIP, feeds the CSR unit.

Function
REQ-016 Register map: 0x0000 msip (bit 0 only, others read 0); 0x4000/0x4004 mtimecmp lo/hi; 0xBFF8/0xBFFC mtime lo/hi.
REQ-017 Any other offset: writes are discarded; the response has resp_error=1 and resp_rdata=0.
REQ-018 Handshake FSM states: IDLE (req_ready=1, resp_valid=0) and RESP (req_ready=0, resp_valid=1).
REQ-019 FSM transitions: an accepted request moves IDLE->RESP on the next edge; RESP->IDLE on resp_valid && resp_ready; RESP holds indefinitely otherwise.
REQ-020 Latency: the response is valid exactly one cycle after acceptance; at most one request outstanding.
REQ-021 resp_rdata and resp_error are captured at acceptance and held stable while in RESP.
REQ-022 Writes take effect at the acceptance edge, byte-merged per req_wstrb; wstrb=0 is a legal no-op write with resp_error=0.
REQ-023 mtime is a 64-bit counter that increments by 1 per tick and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-024 An mtime write in the same cycle as a tick: the written half takes the written value, the other half keeps its pre-tick value, and the tick is lost.
REQ-025 An mtime_lo write does not carry into mtime_hi.
REQ-026 timer_interrupt is registered (mtime >= mtimecmp, unsigned 64-bit), evaluated on post-update values, giving 1 cycle latency from the condition becoming true.
REQ-027 software_interrupt is registered and equals msip bit 0.
REQ-028 Reads return pre-write/pre-tick values of the accepted cycle.

Reset
REQ-029 Reset values: mtime=0; mtimecmp=0xFFFF_FFFF_FFFF_FFFF; msip=0; FSM=IDLE; prescaler=0; all outputs 0 except req_ready=1.
REQ-030 Reset asserted mid-transaction drops any pending response; no write is committed unless its acceptance edge preceded reset.

Configuration
REQ-031 Macro CLINT_PRESCALER_EN, when defined: a tick occurs once every PRESCALE_DIV clk cycles (the prescaler counts 0..PRESCALE_DIV-1, ticking on wrap).
REQ-032 Macro CLINT_PRESCALER_EN, when undefined: a tick occurs every clk cycle, no prescaler logic exists, and PRESCALE_DIV is ignored.

Structure
REQ-033 The shared package riscv_pkg holds the CLINT offset localparams (CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI) and the FSM state enum.
REQ-034 One sub-module, clint_prescaler (tick generator), is instantiated only under CLINT_PRESCALER_EN.

Verification
REQ-035 Reset, then read 0x4004 -> resp_rdata=0xFFFF_FFFF, resp_error=0, timer_interrupt=0.
REQ-036 Write 0x0000 with 0x1 and wstrb=0xF -> software_interrupt=1 one cycle later; write 0x0 -> 0 one cycle later.
REQ-037 Without the macro: write mtimecmp=0x20 (hi=0), mtime=0 -> timer_interrupt rises when mtime reaches 0x20; writing mtimecmp hi=1 clears it one cycle later.
REQ-038 Without the macro: set mtime=0xFFFF_FFFF_FFFF_FFFE -> after 2 ticks read lo=0, hi=0.
REQ-039 Read 0x1234 -> resp_error=1, resp_rdata=0; hold resp_ready=0 for 5 cycles -> resp_valid stays 1 with data stable, req_ready=0.
REQ-040 With the macro and PRESCALE_DIV=4: after 40 cycles from reset, mtime = 10 (±1 at the boundary).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V platform definitions: CLINT register offsets, the CLINT
// bus handshake state encoding and a byte-lane merge helper.
package riscv_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        CLINT_IDLE = 1'b0,
        CLINT_RESP = 1'b1
    } clint_state_e;

    // Replace the bytes of old_val selected by strb with those of new_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Request/response bus between a core-side master and the CLINT slave:
// one request in flight, response returned on a separate valid/ready pair.
interface clint_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/clint_prescaler.sv
// mtime tick generator: counts 0..PRESCALE_DIV-1 and pulses tick_o for the
// single cycle in which the count wraps.
module clint_prescaler #(
    parameter int unsigned PRESCALE_DIV = 16
) (
    input  logic clk,
    input  logic resetn,
    output logic tick_o
);

    localparam logic [15:0] LAST = 16'(PRESCALE_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a free-running 64-bit mtime
// behind a single-outstanding request/response bus. Define CLINT_PRESCALER_EN
// to tick mtime once every PRESCALE_DIV cycles instead of every cycle.
module clint
    import riscv_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 16
) (
    input  logic   clk,
    input  logic   resetn,
    clint_if.slave bus,
    output logic   timer_interrupt_o,
    output logic   software_interrupt_o
);

    clint_state_e state_q, state_d;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        mtip_q, ssip_q;

    logic        tick;
    logic        accept;
    logic        wr_en;
    logic [13:0] word;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi, mapped;
    logic [31:0] rd_word;
    logic [1:0]  unused_addr_lsb;

`ifdef CLINT_PRESCALER_EN
    clint_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .tick_o(tick)
    );
`else
    // PRESCALE_DIV has no effect without the prescaler; mtime counts clk.
    logic [31:0] unused_prescale_div;
    assign unused_prescale_div = 32'(PRESCALE_DIV);
    assign tick                = 1'b1;
`endif

    // Registers are word-aligned; the byte offset within a word is ignored.
    assign unused_addr_lsb = bus.req_addr[1:0];
    assign word            = bus.req_addr[15:2];

    assign sel_msip   = (word == CLINT_MSIP[15:2]);
    assign sel_cmp_lo = (word == CLINT_MTIMECMP_LO[15:2]);
    assign sel_cmp_hi = (word == CLINT_MTIMECMP_HI[15:2]);
    assign sel_mt_lo  = (word == CLINT_MTIME_LO[15:2]);
    assign sel_mt_hi  = (word == CLINT_MTIME_HI[15:2]);
    assign mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;

    assign accept = bus.req_valid && (state_q == CLINT_IDLE);
    assign wr_en  = accept && bus.req_write && (bus.req_wstrb != 4'b0000);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state_q)
            CLINT_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = CLINT_RESP;
            end
            CLINT_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = CLINT_IDLE;
            end
            default: state_d = CLINT_IDLE;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

    // Read mux sees pre-write, pre-tick register values.
    always_comb begin
        rd_word = '0;
        if (sel_msip)   rd_word = {31'b0, msip_q};
        if (sel_cmp_lo) rd_word = mtimecmp_q[31:0];
        if (sel_cmp_hi) rd_word = mtimecmp_q[63:32];
        if (sel_mt_lo)  rd_word = mtime_q[31:0];
        if (sel_mt_hi)  rd_word = mtime_q[63:32];
    end

    // A write to either mtime half replaces the tick for that cycle, and the
    // untouched half keeps its pre-tick value (no carry from lo into hi).
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;
        error_d    = error_q;

        if (accept) begin
            error_d = !mapped;
            rdata_d = (bus.req_write || !mapped) ? 32'h0 : rd_word;
        end

        if (wr_en) begin
            if (sel_msip && bus.req_wstrb[0]) msip_d = bus.req_wdata[0];
            if (sel_cmp_lo)
                mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], bus.req_wdata, bus.req_wstrb);
            if (sel_cmp_hi)
                mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus.req_wdata, bus.req_wstrb);
            if (sel_mt_lo)
                mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.req_wdata, bus.req_wstrb)};
            if (sel_mt_hi)
                mtime_d = {merge_bytes(mtime_q[63:32], bus.req_wdata, bus.req_wstrb), mtime_q[31:0]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= CLINT_IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            mtip_q     <= 1'b0;
            ssip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            mtip_q     <= (mtime_d >= mtimecmp_d);
            ssip_q     <= msip_d;
        end
    end

    assign timer_interrupt_o    = mtip_q;
    assign software_interrupt_o = ssip_q;

endmodule
